// File: rtl/rv_multicycle_ctrl_if.sv
// Control/status bundle between the multicycle RV32I controller and its datapath.
// The master side is the controller: it samples decoded instruction fields and
// datapath status, and drives every select and write enable.
interface rv_multicycle_ctrl_if;
    // Instruction fields and datapath status
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       mem_ready;

    // Datapath controls
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_control;
    logic [1:0] imm_src;
    logic       reg_write;
    logic       illegal_instr;
    logic [3:0] state_dbg;

    modport master (
        input  op, funct3, funct7b5, zero, mem_ready,
        output pc_write, adr_src, mem_write, ir_write, result_src,
               alu_src_a, alu_src_b, alu_control, imm_src, reg_write,
               illegal_instr, state_dbg
    );

    modport slave (
        output op, funct3, funct7b5, zero, mem_ready,
        input  pc_write, adr_src, mem_write, ir_write, result_src,
               alu_src_a, alu_src_b, alu_control, imm_src, reg_write,
               illegal_instr, state_dbg
    );
endinterface

// File: rtl/rv_multicycle_ctrl.sv
// Main control FSM of the multicycle RV32I core. Sequences the shared ALU, the
// unified instruction/data memory port, the register file and the immediate
// extender, and stalls on the memory ready handshake.
// Optional feature macro: RV_JAL_EN -- when defined, JAL is decoded and executed
// through its own state; otherwise opcode 1101111 is reported as illegal.
module rv_multicycle_ctrl #(
    parameter logic [3:0] RESET_STATE = 4'd0,  // FETCH
    parameter bit         ALU_SUB_EN  = 1'b1   // 0: R-type funct7[5] ignored
) (
    input  logic                 clk,
    input  logic                 rst_n,
    rv_multicycle_ctrl_if.master bus
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
`ifdef RV_JAL_EN
    localparam logic [6:0] OP_JAL   = 7'b1101111;
`endif

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    state_t     state_q, state_d;
    logic [2:0] alu_funct;

    // Internal (ungated) control decode of the current state
    logic       pc_update, branch;
    logic       adr_src, mem_write, ir_write, reg_write, illegal_instr;
    logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
    logic [2:0] alu_control;

    // State register; reset abandons any instruction in flight.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= state_t'(RESET_STATE);
        else        state_q <= state_d;
    end

    // ALU operation for R-type and I-type arithmetic, from funct3/funct7[5].
    // op[5] separates R-type (register operand) from I-type, where bit 30
    // belongs to the immediate and must not select subtract.
    always_comb begin
        alu_funct = ALU_ADD;
        case (bus.funct3)
            3'b000:  alu_funct = (ALU_SUB_EN && bus.op[5] && bus.funct7b5) ? ALU_SUB : ALU_ADD;
            3'b010:  alu_funct = ALU_SLT;
            3'b110:  alu_funct = ALU_OR;
            3'b111:  alu_funct = ALU_AND;
            default: alu_funct = ALU_ADD;
        endcase
    end

    // Next-state and Moore control decode; unused selects stay 0.
    // NOTE: every signal written here gets a default first so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d       = S_FETCH;
        pc_update     = 1'b0;
        branch        = 1'b0;
        adr_src       = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        illegal_instr = 1'b0;
        result_src    = 2'b00;
        alu_src_a     = 2'b00;
        alu_src_b     = 2'b00;
        imm_src       = 2'b00;
        alu_control   = ALU_ADD;

        case (state_q)
            S_FETCH: begin
                // PC + 4 computed alongside the instruction read
                result_src = 2'b10;
                alu_src_b  = 2'b10;
                if (bus.mem_ready) begin
                    ir_write  = 1'b1;
                    pc_update = 1'b1;
                    state_d   = S_DECODE;
                end else begin
                    state_d   = S_FETCH;
                end
            end
            S_DECODE: begin
                // Branch/jump target precompute: old PC + immediate
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                imm_src   = 2'b10;
                case (bus.op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECR;
                    OP_ITYPE:          state_d = S_EXECI;
                    OP_BEQ:            state_d = S_BEQ;
`ifdef RV_JAL_EN
                    OP_JAL: begin
                        imm_src = 2'b11;
                        state_d = S_JAL;
                    end
`endif
                    default: begin
                        illegal_instr = 1'b1;
                        state_d       = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                imm_src   = bus.op[5] ? 2'b01 : 2'b00;
                state_d   = bus.op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
                state_d = bus.mem_ready ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWRITE: begin
                // Strobe held for the whole access; memory ignores repeats
                adr_src   = 1'b1;
                mem_write = 1'b1;
                state_d   = bus.mem_ready ? S_FETCH : S_MEMWRITE;
            end
            S_EXECR: begin
                alu_src_a   = 2'b10;
                alu_control = alu_funct;
                state_d     = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a   = 2'b10;
                alu_src_b   = 2'b01;
                alu_control = alu_funct;
                state_d     = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_BEQ: begin
                // ALUOut holds the target computed in DECODE
                alu_src_a   = 2'b10;
                alu_control = ALU_SUB;
                branch      = 1'b1;
                state_d     = S_FETCH;
            end
`ifdef RV_JAL_EN
            S_JAL: begin
                // PC <- target from DECODE; ALU forms old PC + 4 for rd
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_update = 1'b1;
                state_d   = S_ALUWB;
            end
`endif
            default: state_d = S_FETCH;
        endcase
    end

    // Outputs forced quiet while reset is held so nothing writes mid-reset
    assign bus.pc_write      = rst_n & (pc_update | (branch & bus.zero));
    assign bus.adr_src       = rst_n & adr_src;
    assign bus.mem_write     = rst_n & mem_write;
    assign bus.ir_write      = rst_n & ir_write;
    assign bus.reg_write     = rst_n & reg_write;
    assign bus.illegal_instr = rst_n & illegal_instr;
    assign bus.result_src    = rst_n ? result_src  : 2'b00;
    assign bus.alu_src_a     = rst_n ? alu_src_a   : 2'b00;
    assign bus.alu_src_b     = rst_n ? alu_src_b   : 2'b00;
    assign bus.alu_control   = rst_n ? alu_control : 3'b000;
    assign bus.imm_src       = rst_n ? imm_src     : 2'b00;
    assign bus.state_dbg     = rst_n ? state_q     : 4'd0;

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Directed bench for rv_multicycle_ctrl: one vector per clock cycle, each giving
// the inputs for that cycle and the hand-computed state and control outputs.
// A second instance built with ALU_SUB_EN=0 shares the same inputs.
module tb_rv_multicycle_ctrl;

    localparam logic [6:0] LW   = 7'b0000011;
    localparam logic [6:0] SW   = 7'b0100011;
    localparam logic [6:0] RT   = 7'b0110011;
    localparam logic [6:0] IT   = 7'b0010011;
    localparam logic [6:0] BEQ  = 7'b1100011;
    localparam logic [6:0] JAL  = 7'b1101111;
    localparam logic [6:0] BAD  = 7'b0000000;

    typedef struct packed {
        logic       pc_write;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_control;
        logic [1:0] imm_src;
        logic       reg_write;
        logic       illegal_instr;
    } ctrl_t;

    typedef struct {
        logic       rst_n;
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        logic       zero;
        logic       rdy;
        logic [3:0] st;
        ctrl_t      ctrl;
        logic       chk0;
        logic [2:0] alu0;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n_r;
    logic [6:0] op_r;
    logic [2:0] f3_r;
    logic       f7_r, zero_r, rdy_r;

    int checks = 0;
    int errors = 0;
    int step   = 0;

    rv_multicycle_ctrl_if bus ();
    rv_multicycle_ctrl_if bus0 ();

    assign bus.op        = op_r;
    assign bus.funct3    = f3_r;
    assign bus.funct7b5  = f7_r;
    assign bus.zero      = zero_r;
    assign bus.mem_ready = rdy_r;
    assign bus0.op        = op_r;
    assign bus0.funct3    = f3_r;
    assign bus0.funct7b5  = f7_r;
    assign bus0.zero      = zero_r;
    assign bus0.mem_ready = rdy_r;

    rv_multicycle_ctrl #(.RESET_STATE(4'd0), .ALU_SUB_EN(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n_r),
        .bus   (bus)
    );

    rv_multicycle_ctrl #(.RESET_STATE(4'd0), .ALU_SUB_EN(1'b0)) dut_nosub (
        .clk   (clk),
        .rst_n (rst_n_r),
        .bus   (bus0)
    );

    always #5 clk = ~clk;

    function automatic ctrl_t c(input logic pcw, adr, mw, irw,
                                input logic [1:0] rs, sa, sb,
                                input logic [2:0] alu,
                                input logic [1:0] imm,
                                input logic rw, ill);
        ctrl_t r;
        r = '{pcw, adr, mw, irw, rs, sa, sb, alu, imm, rw, ill};
        return r;
    endfunction

    function automatic vec_t row(input logic rst, input logic [6:0] op,
                                 input logic [2:0] f3, input logic f7, zero, rdy,
                                 input logic [3:0] st, input ctrl_t ctrl);
        vec_t v;
        v.rst_n = rst; v.op = op; v.f3 = f3; v.f7 = f7; v.zero = zero; v.rdy = rdy;
        v.st = st; v.ctrl = ctrl; v.chk0 = 1'b0; v.alu0 = 3'b000;
        return v;
    endfunction

    function automatic ctrl_t get_ctrl();
        ctrl_t r;
        r = '{bus.pc_write, bus.adr_src, bus.mem_write, bus.ir_write, bus.result_src,
              bus.alu_src_a, bus.alu_src_b, bus.alu_control, bus.imm_src,
              bus.reg_write, bus.illegal_instr};
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Drive one cycle of inputs, compare mid-cycle, then advance past the edge
    task automatic apply(input vec_t v);
        rst_n_r = v.rst_n; op_r = v.op; f3_r = v.f3; f7_r = v.f7;
        zero_r  = v.zero;  rdy_r = v.rdy;
        @(negedge clk);
        check($sformatf("step%0d state_dbg", step), 32'(bus.state_dbg), 32'(v.st));
        check($sformatf("step%0d controls", step), 32'(get_ctrl()), 32'(v.ctrl));
        if (v.chk0)
            check($sformatf("step%0d nosub alu_control", step), 32'(bus0.alu_control), 32'(v.alu0));
        step++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        ctrl_t e_zero, e_fetch_go, e_fetch_wait, e_decode, e_illegal;
        ctrl_t e_memadr_l, e_memadr_s, e_memread, e_memwb, e_memwrite, e_aluwb;
        vec_t  vecs[$];
        vec_t  v;

        //                pcw adr mw irw rs     sa     sb     alu     imm    rw ill
        e_zero       = c(0,  0,  0, 0,  2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 0, 0);
        e_fetch_go   = c(1,  0,  0, 1,  2'b10, 2'b00, 2'b10, 3'b000, 2'b00, 0, 0);
        e_fetch_wait = c(0,  0,  0, 0,  2'b10, 2'b00, 2'b10, 3'b000, 2'b00, 0, 0);
        e_decode     = c(0,  0,  0, 0,  2'b00, 2'b01, 2'b01, 3'b000, 2'b10, 0, 0);
        e_illegal    = c(0,  0,  0, 0,  2'b00, 2'b01, 2'b01, 3'b000, 2'b10, 0, 1);
        e_memadr_l   = c(0,  0,  0, 0,  2'b00, 2'b10, 2'b01, 3'b000, 2'b00, 0, 0);
        e_memadr_s   = c(0,  0,  0, 0,  2'b00, 2'b10, 2'b01, 3'b000, 2'b01, 0, 0);
        e_memread    = c(0,  1,  0, 0,  2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 0, 0);
        e_memwb      = c(0,  0,  0, 0,  2'b01, 2'b00, 2'b00, 3'b000, 2'b00, 1, 0);
        e_memwrite   = c(0,  1,  1, 0,  2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 0, 0);
        e_aluwb      = c(0,  0,  0, 0,  2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1, 0);

        // Reset, then lw with memory always ready: 0,1,2,3,4,0
        vecs.push_back(row(0, LW, 3'b010, 0, 0, 1, 4'd0, e_zero));
        vecs.push_back(row(0, LW, 3'b010, 0, 0, 1, 4'd0, e_zero));
        vecs.push_back(row(1, LW, 3'b010, 0, 0, 1, 4'd0, e_fetch_go));
        vecs.push_back(row(1, LW, 3'b010, 0, 0, 1, 4'd1, e_decode));
        vecs.push_back(row(1, LW, 3'b010, 0, 0, 1, 4'd2, e_memadr_l));
        vecs.push_back(row(1, LW, 3'b010, 0, 0, 1, 4'd3, e_memread));
        vecs.push_back(row(1, LW, 3'b010, 0, 0, 1, 4'd4, e_memwb));
        vecs.push_back(row(1, LW, 3'b010, 0, 0, 0, 4'd0, e_fetch_wait));
        // sw with three not-ready cycles in MEMWRITE
        vecs.push_back(row(1, SW, 3'b010, 0, 0, 1, 4'd0, e_fetch_go));
        vecs.push_back(row(1, SW, 3'b010, 0, 0, 1, 4'd1, e_decode));
        vecs.push_back(row(1, SW, 3'b010, 0, 0, 1, 4'd2, e_memadr_s));
        vecs.push_back(row(1, SW, 3'b010, 0, 0, 0, 4'd5, e_memwrite));
        vecs.push_back(row(1, SW, 3'b010, 0, 0, 0, 4'd5, e_memwrite));
        vecs.push_back(row(1, SW, 3'b010, 0, 0, 0, 4'd5, e_memwrite));
        vecs.push_back(row(1, SW, 3'b010, 0, 0, 1, 4'd5, e_memwrite));
        // ori
        vecs.push_back(row(1, IT, 3'b110, 0, 0, 1, 4'd0, e_fetch_go));
        vecs.push_back(row(1, IT, 3'b110, 0, 0, 1, 4'd1, e_decode));
        vecs.push_back(row(1, IT, 3'b110, 0, 0, 1, 4'd7, c(0,0,0,0,2'b00,2'b10,2'b01,3'b011,2'b00,0,0)));
        vecs.push_back(row(1, IT, 3'b110, 0, 0, 1, 4'd8, e_aluwb));
        // beq taken, then not taken
        vecs.push_back(row(1, BEQ, 3'b000, 0, 1, 1, 4'd0, e_fetch_go));
        vecs.push_back(row(1, BEQ, 3'b000, 0, 1, 1, 4'd1, e_decode));
        vecs.push_back(row(1, BEQ, 3'b000, 0, 1, 1, 4'd9, c(1,0,0,0,2'b00,2'b10,2'b00,3'b001,2'b00,0,0)));
        vecs.push_back(row(1, BEQ, 3'b000, 0, 0, 1, 4'd0, e_fetch_go));
        vecs.push_back(row(1, BEQ, 3'b000, 0, 0, 1, 4'd1, e_decode));
        vecs.push_back(row(1, BEQ, 3'b000, 0, 0, 1, 4'd9, c(0,0,0,0,2'b00,2'b10,2'b00,3'b001,2'b00,0,0)));
        // Illegal opcode 0000000
        vecs.push_back(row(1, BAD, 3'b000, 0, 0, 1, 4'd0, e_fetch_go));
        vecs.push_back(row(1, BAD, 3'b000, 0, 0, 1, 4'd1, e_illegal));
        vecs.push_back(row(1, BAD, 3'b000, 0, 0, 0, 4'd0, e_fetch_wait));
        // slti
        vecs.push_back(row(1, IT, 3'b010, 0, 0, 1, 4'd0, e_fetch_go));
        vecs.push_back(row(1, IT, 3'b010, 0, 0, 1, 4'd1, e_decode));
        vecs.push_back(row(1, IT, 3'b010, 0, 0, 1, 4'd7, c(0,0,0,0,2'b00,2'b10,2'b01,3'b101,2'b00,0,0)));
        vecs.push_back(row(1, IT, 3'b010, 0, 0, 1, 4'd8, e_aluwb));
        // addi with Instr[30]=1: immediate bit, must stay add
        vecs.push_back(row(1, IT, 3'b000, 1, 0, 1, 4'd0, e_fetch_go));
        vecs.push_back(row(1, IT, 3'b000, 1, 0, 1, 4'd1, e_decode));
        vecs.push_back(row(1, IT, 3'b000, 1, 0, 1, 4'd7, c(0,0,0,0,2'b00,2'b10,2'b01,3'b000,2'b00,0,0)));
        vecs.push_back(row(1, IT, 3'b000, 1, 0, 1, 4'd8, e_aluwb));
        // and (R-type)
        vecs.push_back(row(1, RT, 3'b111, 0, 0, 1, 4'd0, e_fetch_go));
        vecs.push_back(row(1, RT, 3'b111, 0, 0, 1, 4'd1, e_decode));
        vecs.push_back(row(1, RT, 3'b111, 0, 0, 1, 4'd6, c(0,0,0,0,2'b00,2'b10,2'b00,3'b010,2'b00,0,0)));
        vecs.push_back(row(1, RT, 3'b111, 0, 0, 1, 4'd8, e_aluwb));
        // Stalled fetch with zero=1 must not write the PC
        vecs.push_back(row(1, BEQ, 3'b000, 0, 1, 0, 4'd0, e_fetch_wait));

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

        // Reset for two cycles in the middle of a stalled lw
        apply(row(1, LW, 3'b010, 0, 0, 1, 4'd0, e_fetch_go));
        apply(row(1, LW, 3'b010, 0, 0, 1, 4'd1, e_decode));
        apply(row(1, LW, 3'b010, 0, 0, 1, 4'd2, e_memadr_l));
        apply(row(1, LW, 3'b010, 0, 0, 0, 4'd3, e_memread));
        apply(row(0, LW, 3'b010, 0, 1, 1, 4'd0, e_zero));
        apply(row(0, LW, 3'b010, 0, 1, 1, 4'd0, e_zero));
        apply(row(1, LW, 3'b010, 0, 0, 1, 4'd0, e_fetch_go));
        apply(row(1, LW, 3'b010, 0, 0, 1, 4'd1, e_decode));
        apply(row(1, LW, 3'b010, 0, 0, 1, 4'd2, e_memadr_l));
        apply(row(1, LW, 3'b010, 0, 0, 1, 4'd3, e_memread));
        apply(row(1, LW, 3'b010, 0, 0, 1, 4'd4, e_memwb));

        // add then sub; the ALU_SUB_EN=0 instance adds in both
        apply(row(1, RT, 3'b000, 0, 0, 1, 4'd0, e_fetch_go));
        apply(row(1, RT, 3'b000, 0, 0, 1, 4'd1, e_decode));
        v = row(1, RT, 3'b000, 0, 0, 1, 4'd6, c(0,0,0,0,2'b00,2'b10,2'b00,3'b000,2'b00,0,0));
        v.chk0 = 1'b1; v.alu0 = 3'b000;
        apply(v);
        apply(row(1, RT, 3'b000, 0, 0, 1, 4'd8, e_aluwb));
        apply(row(1, RT, 3'b000, 1, 0, 1, 4'd0, e_fetch_go));
        apply(row(1, RT, 3'b000, 1, 0, 1, 4'd1, e_decode));
        v = row(1, RT, 3'b000, 1, 0, 1, 4'd6, c(0,0,0,0,2'b00,2'b10,2'b00,3'b001,2'b00,0,0));
        v.chk0 = 1'b1; v.alu0 = 3'b000;
        apply(v);
        apply(row(1, RT, 3'b000, 1, 0, 1, 4'd8, e_aluwb));

        // jal
        apply(row(1, JAL, 3'b000, 0, 0, 1, 4'd0, e_fetch_go));
`ifdef RV_JAL_EN
        apply(row(1, JAL, 3'b000, 0, 0, 1, 4'd1, c(0,0,0,0,2'b00,2'b01,2'b01,3'b000,2'b11,0,0)));
        apply(row(1, JAL, 3'b000, 0, 0, 1, 4'd10, c(1,0,0,0,2'b00,2'b01,2'b10,3'b000,2'b00,0,0)));
        apply(row(1, JAL, 3'b000, 0, 0, 1, 4'd8, e_aluwb));
`else
        apply(row(1, JAL, 3'b000, 0, 0, 1, 4'd1, e_illegal));
`endif
        apply(row(1, JAL, 3'b000, 0, 0, 0, 4'd0, e_fetch_wait));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
